peripheral_pwm_multi: RTL
=========================

# peripheral_pwm_multi

Parametrised multi-channel PWM peripheral on the CPU's simple memory-mapped bus. It is the successor to the fixed 8-channel PWM peripheral and provides NCH independent channels of CW-bit resolution. Each channel has edge- or center-aligned mode, output polarity, double-buffered period/duty with glitch-free update at period end, and a period-end interrupt. It sits beside the other bus peripherals and drives the `pwm` pins directly.

## Interface
- `NCH`, 8, number of channels (1..16)
- `CW`, 16, counter/period/duty width (2..32)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `addr`  in  16  byte address, word aligned (addr[1:0] ignored)
- `datain`  in  32  write data
- `w`  in  1  write strobe, one write per cycle it is high
- `r`  in  1  read strobe
- `dataout`  out  32  registered read data
- `pwm`  out  NCH  registered channel outputs
- `irq`  out  1  registered interrupt request

## Operation
- Register map. Offsets are shown for NCH=8; global registers start at G=4+8*NCH.
  - 0x00 EN[NCH-1:0]: channel enable.
  - 4+8i PERIOD_BUF[i].
  - 8+8i DUTY_BUF[i].
  - G+0 STATUS: sticky period-end flags, write-1-to-clear.
  - G+4 MODE: 1 = center-aligned.
  - G+8 POL: 1 = inverted output.
  - G+12 IRQEN.
- Unused high bits of writes are discarded. Unused bits read 0. Unmapped addresses read 0; writes to them are ignored.
- Each channel has a counter `cnt` (CW bits), a direction bit, and active registers PER_A and DUT_A.
- Disabled channel (EN[i]=0):
  - cnt=0, direction up.
  - PER_A/DUT_A follow the buffers every cycle.
  - pwm[i]=POL[i].
  - No STATUS events.
- Edge mode: cnt counts 0..PER_A, then wraps to 0. Period = PER_A+1 cycles. A period end occurs on the cycle cnt==PER_A.
- Center mode:
  - cnt counts up 0..PER_A, then down PER_A-1..1, then returns to 0.
  - Period = 2*PER_A cycles. A period end occurs on the cycle cnt==1 while counting down.
  - If PER_A=0, cnt stays 0 and a period end occurs every cycle.
- At each period end, PER_A<=PERIOD_BUF and DUT_A<=DUTY_BUF. Mid-period buffer writes never alter the current period.
- Output: pwm[i] <= EN[i] ? ((cnt<DUT_A) ^ POL[i]) : POL[i]. The comparison is unsigned and CW bits wide.
  - DUTY=0 gives constant inactive.
  - DUTY>PERIOD gives constant active.
- STATUS[i] is set at period end of an enabled channel. It is cleared by writing 1 to that bit. A set and a clear in the same cycle: the set wins.
- irq <= |(STATUS & IRQEN).
- Reads return buffer values (not active values), EN, STATUS, MODE, POL, and IRQEN.
- If r and w are both high, the write executes and dataout returns the pre-write value.

## Timing
- Reset values: all registers 0, cnt 0, pwm 0, dataout 0, irq 0.
- Write: takes effect at the clock edge where w=1.
- Read: dataout is valid one cycle after the edge sampling r=1. dataout holds its last value while r=0.
- Enable written at edge N: first pwm value at edge N+1, computed from cnt=0 and the buffers as of edge N.
- Disable at edge N: pwm=POL and cnt=0 from edge N+1.
- STATUS is set at the edge after the period-end cycle. irq follows one edge later.
- A reset asserted mid-period forces all outputs to their reset values immediately, independent of clk.

## Test plan
1. Reset, then read every mapped address -> all read 0; pwm=0, irq=0. Unmapped 0x7C reads 0.
2. Ch0 edge mode: write PERIOD=9 and DUTY=3, then EN=0x01 -> pwm[0] is high 3 cycles, low 7, repeating with a 10-cycle period. Other pwm bits stay 0.
3. Ch0 running at DUTY=3: write DUTY=5 at cycle 1 of a period.
   - Readback returns 5 next cycle.
   - The current period stays high 3 cycles; the next period is high 5.
4. Ch1: MODE bit1=1, PERIOD=4, DUTY=2 -> cnt sequence 0,1,2,3,4,3,2,1 repeats. pwm[1] is high at cnt 0,1 and the trailing 1: 3 of 8 cycles.
5. Boundary cases:
   - DUTY=0 -> pwm constant 0.
   - DUTY=20 with PERIOD=9 -> pwm constant 1.
   - POL=1 inverts both cases.
   - Clear EN mid-period -> pwm=POL next cycle. Re-enable restarts at cnt=0.
6. Interrupt: IRQEN=0x01, ch0 running.
   - First period end sets STATUS=0x01, and irq rises one cycle later.
   - Writing STATUS=0x01 clears it.
   - A clear written on the period-end edge leaves STATUS=0x01.

Source files
------------

// File: rtl/peripheral_pwm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | peripheral_pwm_multi: NCH-channel PWM, double-buffered period/duty, irq    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module peripheral_pwm_multi #(
  parameter int NCH = 8,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    addr,
  input  logic [31:0]    datain,
  input  logic           w,
  input  logic           r,
  output logic [31:0]    dataout,
  output logic [NCH-1:0] pwm,
  output logic           irq
);

  localparam int          G_WORD = 1 + 2 * NCH;
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [13:0]    word_w;
  logic [NCH-1:0] en_q, status_q, mode_q, pol_q, irqen_q;
  logic [NCH-1:0] status_d, pe_w;
  logic [CW-1:0]  per_buf_q  [NCH];
  logic [CW-1:0]  duty_buf_q [NCH];
  logic [NCH-1:0] wr_per_w, wr_duty_w;
  logic           wr_en_w, wr_stat_w, wr_mode_w, wr_pol_w, wr_irqen_w;
  logic [31:0]    rdata_w, dataout_q;
  logic           irq_q;
  logic           unused_w;

  assign word_w   = addr[15:2];
  assign unused_w = ^{addr[1:0], datain};

  always_comb begin
    wr_en_w    = w && (word_w == 14'd0);
    wr_stat_w  = w && (word_w == 14'(G_WORD));
    wr_mode_w  = w && (word_w == 14'(G_WORD + 1));
    wr_pol_w   = w && (word_w == 14'(G_WORD + 2));
    wr_irqen_w = w && (word_w == 14'(G_WORD + 3));
    for (int i = 0; i < NCH; i++) begin
      wr_per_w[i]  = w && (word_w == 14'(1 + 2 * i));
      wr_duty_w[i] = w && (word_w == 14'(2 + 2 * i));
    end
  end

  // Read mux always sees pre-write state, so a read+write returns the old value.
  always_comb begin
    rdata_w = '0;
    if (word_w == 14'd0)                rdata_w[NCH-1:0] = en_q;
    if (word_w == 14'(G_WORD))          rdata_w[NCH-1:0] = status_q;
    if (word_w == 14'(G_WORD + 1))      rdata_w[NCH-1:0] = mode_q;
    if (word_w == 14'(G_WORD + 2))      rdata_w[NCH-1:0] = pol_q;
    if (word_w == 14'(G_WORD + 3))      rdata_w[NCH-1:0] = irqen_q;
    for (int i = 0; i < NCH; i++) begin
      if (word_w == 14'(1 + 2 * i))     rdata_w[CW-1:0] = per_buf_q[i];
      if (word_w == 14'(2 + 2 * i))     rdata_w[CW-1:0] = duty_buf_q[i];
    end
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    status_d = (status_q & ~(wr_stat_w ? datain[NCH-1:0] : '0)) | pe_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= '0;
      status_q  <= '0;
      mode_q    <= '0;
      pol_q     <= '0;
      irqen_q   <= '0;
      dataout_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_en_w)    en_q    <= datain[NCH-1:0];
      if (wr_mode_w)  mode_q  <= datain[NCH-1:0];
      if (wr_pol_w)   pol_q   <= datain[NCH-1:0];
      if (wr_irqen_w) irqen_q <= datain[NCH-1:0];
      status_q <= status_d;
      irq_q    <= |(status_q & irqen_q);
      if (r) dataout_q <= rdata_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        per_buf_q[i]  <= '0;
        duty_buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_per_w[i])  per_buf_q[i]  <= datain[CW-1:0];
        if (wr_duty_w[i]) duty_buf_q[i] <= datain[CW-1:0];
      end
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [CW-1:0] cnt_q, cnt_d, per_a_q, per_a_d, dut_a_q, dut_a_d;
      logic          dir_q, dir_d, pwm_q, pwm_d, pe;

      // dir_q=1 means counting down (center mode only).
      always_comb begin
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        per_a_d = per_a_q;
        dut_a_d = dut_a_q;
        pe      = 1'b0;
        if (!en_q[i]) begin
          cnt_d   = '0;
          dir_d   = 1'b0;
          per_a_d = per_buf_q[i];
          dut_a_d = duty_buf_q[i];
        end else if (!mode_q[i]) begin
          dir_d = 1'b0;
          if (cnt_q == per_a_q) begin
            pe    = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (per_a_q == '0) begin
          pe    = 1'b1;
          cnt_d = '0;
          dir_d = 1'b0;
        end else if (cnt_q == ONE && (dir_q || per_a_q == ONE)) begin
          // PER_A=1 has no down-slope, so the top is also the period end.
          pe    = 1'b1;
          cnt_d = '0;
          dir_d = 1'b0;
        end else if (dir_q || cnt_q == per_a_q) begin
          dir_d = 1'b1;
          cnt_d = cnt_q - ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        if (pe) begin
          per_a_d = per_buf_q[i];
          dut_a_d = duty_buf_q[i];
        end
        pwm_d = en_q[i] ? ((cnt_q < dut_a_q) ^ pol_q[i]) : pol_q[i];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q   <= '0;
          dir_q   <= 1'b0;
          per_a_q <= '0;
          dut_a_q <= '0;
          pwm_q   <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          dir_q   <= dir_d;
          per_a_q <= per_a_d;
          dut_a_q <= dut_a_d;
          pwm_q   <= pwm_d;
        end
      end

      assign pwm[i]  = pwm_q;
      assign pe_w[i] = pe;
    end
  endgenerate

  assign dataout = dataout_q;
  assign irq     = irq_q;

endmodule
`default_nettype wire
